// File: rtl/fe_tx_burst_sched.sv
// Burst descriptor scheduler: queues host descriptors, presents the head to the
// TX burst chain, retires on launch/completion strobes and returns sample credits.
module fe_tx_burst_sched #(
    parameter int LOW_ADDDR_BITS = 13,
    parameter int TS_BITS        = 30,
    parameter int DESC_LOG2      = 4,
    parameter int CNT_BITS       = 16
) (
    input  logic                      mclk,
    input  logic                      arst,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [TS_BITS-1:0]        desc_start,
    input  logic [LOW_ADDDR_BITS-1:0] desc_samples,
    input  logic                      flush,
    output logic                      ts_rd_valid,
    output logic [TS_BITS-1:0]        ts_rd_start,
    output logic [LOW_ADDDR_BITS-1:0] ts_rd_samples,
    input  logic                      ts_rd_addr_inc,
    input  logic                      ts_rd_addr_processed_inc,
    input  logic [TS_BITS-1:0]        ts_rd_addr_late_samples,
    input  logic [TS_BITS-1:0]        late_tol,
    output logic                      rel_valid,
    output logic [LOW_ADDDR_BITS-1:0] rel_samples,
    output logic [DESC_LOG2:0]        q_used,
    output logic [DESC_LOG2:0]        q_inflight,
    input  logic                      stat_clr,
    output logic [CNT_BITS-1:0]       stat_late_cnt,
    output logic [TS_BITS-1:0]        stat_late_max,
    output logic                      proto_err
);

    localparam int DEPTH = 1 << DESC_LOG2;
    localparam int PW    = DESC_LOG2 + 1;
    localparam int DW    = TS_BITS + LOW_ADDDR_BITS;

    logic [DW-1:0]             r_mem [DEPTH];
    logic [PW-1:0]             r_wp;
    logic [PW-1:0]             r_lp;
    logic [PW-1:0]             r_dp;
    logic                      r_desc_ready;
    logic                      r_rel_valid;
    logic [LOW_ADDDR_BITS-1:0] r_rel_samples;
    logic [PW-1:0]             r_q_used;
    logic [PW-1:0]             r_q_inflight;
    logic [CNT_BITS-1:0]       r_late_cnt;
    logic [TS_BITS-1:0]        r_late_max;
    logic                      r_proto_err;

    logic          w_head_valid;
    logic          w_any_inflight;
    logic          w_launch;
    logic          w_done;
    logic          w_write;
    logic          w_late_pos;
    logic          w_late_over;
    logic          w_late_newmax;
    logic [PW-1:0] w_lp_nxt;
    logic [PW-1:0] w_wp_nxt;
    logic [PW-1:0] w_dp_nxt;
    logic [PW-1:0] w_used_nxt;
    logic [PW-1:0] w_infl_nxt;
    logic [DW-1:0] w_head;
    logic [DW-1:0] w_tail;

    assign w_head_valid   = (r_wp != r_lp);
    assign w_any_inflight = (r_dp != r_lp);
    assign w_launch       = ts_rd_addr_inc && w_head_valid;
    assign w_done         = ts_rd_addr_processed_inc && w_any_inflight;
    assign w_write        = desc_valid && r_desc_ready && !flush;

    // Flush collapses the unlaunched region onto the post-launch pointer.
    assign w_lp_nxt   = w_launch ? r_lp + PW'(1) : r_lp;
    assign w_wp_nxt   = flush ? w_lp_nxt : (w_write ? r_wp + PW'(1) : r_wp);
    assign w_dp_nxt   = w_done ? r_dp + PW'(1) : r_dp;
    assign w_used_nxt = w_wp_nxt - w_dp_nxt;
    assign w_infl_nxt = w_lp_nxt - w_dp_nxt;

    // Negative lateness (early launch) never contributes to statistics.
    assign w_late_pos    = !ts_rd_addr_late_samples[TS_BITS-1];
    assign w_late_over   = w_launch && w_late_pos && (ts_rd_addr_late_samples > late_tol);
    assign w_late_newmax = w_launch && w_late_pos && (ts_rd_addr_late_samples > r_late_max);

    assign w_head = r_mem[r_lp[DESC_LOG2-1:0]];
    assign w_tail = r_mem[r_dp[DESC_LOG2-1:0]];

    always_ff @(posedge mclk) begin
        if (w_write) begin
            r_mem[r_wp[DESC_LOG2-1:0]] <= {desc_start, desc_samples};
        end
    end

    always_ff @(posedge mclk) begin
        if (arst) begin
            r_wp          <= '0;
            r_lp          <= '0;
            r_dp          <= '0;
            r_desc_ready  <= 1'b1;
            r_rel_valid   <= 1'b0;
            r_rel_samples <= '0;
            r_q_used      <= '0;
            r_q_inflight  <= '0;
            r_late_cnt    <= '0;
            r_late_max    <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_wp         <= w_wp_nxt;
            r_lp         <= w_lp_nxt;
            r_dp         <= w_dp_nxt;
            r_desc_ready <= (w_used_nxt != PW'(DEPTH));
            r_q_used     <= w_used_nxt;
            r_q_inflight <= w_infl_nxt;
            r_rel_valid  <= w_done;
            if (w_done) begin
                r_rel_samples <= w_tail[LOW_ADDDR_BITS-1:0];
            end
            if ((ts_rd_addr_inc && !w_head_valid) ||
                (ts_rd_addr_processed_inc && !w_any_inflight)) begin
                r_proto_err <= 1'b1;
            end
            if (stat_clr) begin
                r_late_cnt <= '0;
                r_late_max <= '0;
            end else begin
                if (w_late_over && (r_late_cnt != {CNT_BITS{1'b1}})) begin
                    r_late_cnt <= r_late_cnt + CNT_BITS'(1);
                end
                if (w_late_newmax) begin
                    r_late_max <= ts_rd_addr_late_samples;
                end
            end
        end
    end

    assign desc_ready    = r_desc_ready;
    assign ts_rd_valid   = w_head_valid;
    assign ts_rd_start   = w_head[DW-1:LOW_ADDDR_BITS];
    assign ts_rd_samples = w_head[LOW_ADDDR_BITS-1:0];
    assign rel_valid     = r_rel_valid;
    assign rel_samples   = r_rel_samples;
    assign q_used        = r_q_used;
    assign q_inflight    = r_q_inflight;
    assign stat_late_cnt = r_late_cnt;
    assign stat_late_max = r_late_max;
    assign proto_err     = r_proto_err;

endmodule

// File: doc/fe_tx_burst_sched.md
Name: fe_tx_burst_sched

Overview:
Burst descriptor scheduler for the TX front-end burst chain. It queues host-written burst descriptors (start timestamp, sample count) and presents the queue head on the chain's ts_rd_valid / ts_rd_start / ts_rd_samples interface. It retires descriptors on the chain's launch and completion strobes and returns freed FIFO sample credits to the DMA side. It also collects late-start statistics.

Parameters:
LOW_ADDDR_BITS, 13, width of the sample-count field (matches the TX FIFO address width)
TS_BITS, 30, timestamp width
DESC_LOG2, 4, log2 of descriptor queue depth (16 entries)
CNT_BITS, 16, width of the statistics counters

Ports:
mclk  in  1  clock
arst  in  1  reset, synchronous, active-high
desc_valid  in  1  descriptor write request
desc_ready  out  1  queue can accept a descriptor
desc_start  in  TS_BITS  burst start timestamp
desc_samples  in  LOW_ADDDR_BITS  burst length, passed to the chain unchanged
flush  in  1  discard all queued, unlaunched descriptors
ts_rd_valid  out  1  head descriptor available
ts_rd_start  out  TS_BITS  head start timestamp
ts_rd_samples  out  LOW_ADDDR_BITS  head length
ts_rd_addr_inc  in  1  chain launched the head descriptor
ts_rd_addr_processed_inc  in  1  chain finished the oldest in-flight burst
ts_rd_addr_late_samples  in  TS_BITS  chain lateness value (two's complement)
late_tol  in  TS_BITS  allowed lateness, unsigned
rel_valid  out  1  credit release strobe, one cycle
rel_samples  out  LOW_ADDDR_BITS  length of the completed burst
q_used  out  DESC_LOG2+1  entries written but not yet completed
q_inflight  out  DESC_LOG2+1  entries launched but not yet completed
stat_clr  in  1  clear statistics
stat_late_cnt  out  CNT_BITS  number of late launches, saturating
stat_late_max  out  TS_BITS  largest lateness seen
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Storage: descriptor RAM of 2^DESC_LOG2 entries, each TS_BITS+LOW_ADDDR_BITS wide.
- Three pointers, each DESC_LOG2+1 bits with a wrap bit: wp (write), lp (launch), dp (done). Invariant: dp <= lp <= wp, modulo arithmetic.
- Reset: all pointers 0; ts_rd_valid=0; desc_ready=1; rel_valid=0; both statistics 0; proto_err=0; q_used=0; q_inflight=0.
- Write: accept when desc_valid && desc_ready. Store the entry at wp, then wp++. desc_ready = (wp-dp) != 2^DESC_LOG2, registered from next-state values so there are no combinational paths from inputs.
- Head: ts_rd_valid = (wp != lp). ts_rd_start and ts_rd_samples = mem[lp], asynchronous read. A descriptor written in cycle N is visible on the head no earlier than N+1.
- Launch: on ts_rd_addr_inc, lp++ and the next head is valid the following cycle. If ts_rd_addr_inc arrives with lp == wp, it is ignored and proto_err is set.
- Lateness: on a valid launch, L = ts_rd_addr_late_samples.
  - If L[TS_BITS-1]==0 and L > late_tol, stat_late_cnt increments (saturating at all-ones).
  - stat_late_max = max(stat_late_max, L).
  - Negative values of L are ignored.
- Complete: on ts_rd_addr_processed_inc with dp != lp, then in the next cycle rel_valid=1 and rel_samples = mem[dp] (value captured before the pointer moves), and dp++. If dp == lp, it is ignored and proto_err is set.
- Simultaneous events: write, launch and complete in the same cycle are all applied. Launch and complete of the same entry in the same cycle is legal only if that entry was already in flight; launch uses lp and complete uses dp independently.
- Flush: lp and wp are set to lp, dropping unlaunched entries. In-flight entries still complete normally. Flush has priority over a simultaneous write, and the written descriptor is dropped. A launch in the same cycle is applied before the flush (lp+1, then wp = lp+1).
- q_used = wp-dp and q_inflight = lp-dp, both registered.
- stat_clr zeroes both statistics. It does not clear proto_err; only arst clears it. An increment in the same cycle as stat_clr is lost.
- Reset mid-burst discards all state. The chain must be reset in the same cycle, since both share arst.

Test Plan:
- Write 3 descriptors (start 100/200/300, samples 10/20/30) → ts_rd_valid=1 with start=100; q_used=3; desc_ready=1.
- Fill 16 entries → desc_ready=0 on the next cycle; a 17th desc_valid is not accepted; one completion → desc_ready=1.
- Launch then complete the first entry → rel_valid one cycle with rel_samples=10; q_used=2; q_inflight=0.
- late_tol=4, launches with L=3, 9, -5, 7 → stat_late_cnt=2; stat_late_max=9; stat_clr → both 0.
- 2 in flight + 3 queued, assert flush → ts_rd_valid=0; two completions give rel_samples in order; q_used=0.
- ts_rd_addr_processed_inc with empty in-flight set → proto_err=1, pointers unchanged, flag survives stat_clr, cleared by arst.
